uart_tx_ctrl: RTL and testbench

Transmit-side sequencer for the UART. It accepts a byte over a valid/ready handshake and latches the baud configuration for the whole frame. It drives the reset and frequency select of an external `uart_clk_div` instance (`RESET_TO_HALF = 0`) and consumes that divider's bit tick. From those ticks it serialises a start bit, the data bits LSB first, an optional parity bit and 1 or 2 stop bits onto the TX line.

---
 rtl/uart_tx_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side UART sequencer.
//
// Accepts a byte on a valid/ready handshake and latches the baud selection
// for the whole frame. It drives an external uart_clk_div (reset + frequency
// select) and uses that divider's bit tick to shift a frame onto the line:
// a start bit, DATA_BITS data bits LSB first, an optional parity bit, and
// STOP_BITS stop bits.
//
// Ports:
//   i_clk        clock for all logic
//   i_rst_n      asynchronous active-low reset
//   i_freq       requested baud rate, sampled on acceptance only
//   i_data       byte to transmit
//   i_valid      i_data is valid
//   o_ready      byte can be accepted this cycle (combinational)
//   o_tx         serial line, idles high, registered
//   o_busy       a frame is in progress
//   o_done       one-cycle pulse after the last stop bit
//   o_div_rst    reset for the external divider
//   o_freq       frequency select for the external divider (latched)
//   i_baud_tick  bit tick from the external divider

package uart_pkg;
   typedef enum logic [2:0] {
      uart_9600   = 3'd0,
      uart_19200  = 3'd1,
      uart_38400  = 3'd2,
      uart_57600  = 3'd3,
      uart_115200 = 3'd4
   } uart_freq;

   // Divider terminal counts for a 1.8432 MHz system clock: clk/baud - 1.
   localparam int UART_9600_CNT   = 191;
   localparam int UART_19200_CNT  = 95;
   localparam int UART_38400_CNT  = 47;
   localparam int UART_57600_CNT  = 31;
   localparam int UART_115200_CNT = 15;
endpackage

module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  uart_freq             i_freq,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_div_rst,
   output uart_freq             o_freq,
   input  logic                 i_baud_tick
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);
   localparam logic PAR_ODD   = (PARITY_ODD != 0);
   localparam logic PAR_EN    = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   stop_q, stop_d;
   logic                   par_q, par_d;
   uart_freq               freq_q, freq_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic                   div_rst_q, div_rst_d;
   logic                   tick;
   logic                   accept;

   // Only the five supported rates may start a frame; any other encoding
   // would leave the divider at a terminal count of zero.
   function automatic logic freq_ok(input uart_freq f);
      return f inside {uart_9600, uart_19200, uart_38400, uart_57600, uart_115200};
   endfunction

   assign o_ready = (state_q == S_IDLE) && freq_ok(i_freq);
   assign accept  = i_valid && o_ready;
   // Ticks while the divider is still held in reset are stale.
   assign tick    = i_baud_tick && !div_rst_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      stop_d    = stop_q;
      par_d     = par_q;
      freq_d    = freq_q;
      done_d    = 1'b0;
      div_rst_d = div_rst_q;
      tx_d      = 1'b1;

      case (state_q)
         S_IDLE: begin
            div_rst_d = 1'b1;
            if (accept) begin
               shift_d   = i_data;
               freq_d    = i_freq;
               par_d     = (^i_data) ^ PAR_ODD;
               idx_d     = '0;
               stop_d    = 1'b0;
               div_rst_d = 1'b0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
                  div_rst_d = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The line level is registered from the next state so the bit change
      // lands on the same edge as the state change.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         stop_q    <= 1'b0;
         par_q     <= 1'b0;
         freq_q    <= uart_9600;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         div_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         stop_q    <= stop_d;
         par_q     <= par_d;
         freq_q    <= freq_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         div_rst_q <= div_rst_d;
      end
   end

   assign o_tx      = tx_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_done    = done_q;
   assign o_div_rst = div_rst_q;
   assign o_freq    = freq_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl.
// Three instances: 8N1 (g=0), 8E2 (g=1), 8O2 (g=2), each paired with a
// behavioural model of uart_clk_div (RESET_TO_HALF = 0).
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   uart_freq   freq = uart_115200;
   logic [7:0] data = 8'h00;
   logic [2:0] valid = 3'b000;
   logic [2:0] ready, tx, busy, done, div_rst, tick;
   uart_freq   dfreq [3];
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   function automatic int cnt_of(input uart_freq f);
      case (f)
         uart_9600:   return UART_9600_CNT;
         uart_19200:  return UART_19200_CNT;
         uart_38400:  return UART_38400_CNT;
         uart_57600:  return UART_57600_CNT;
         uart_115200: return UART_115200_CNT;
         default:     return 0;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [7:0] cnt = 8'd0;
      logic [7:0] cmax;
      // Divider model: counter held at 0 in reset, tick while at terminal count.
      assign cmax    = 8'(cnt_of(dfreq[g]));
      assign tick[g] = (cnt == cmax);
      always @(posedge clk) begin
         if (div_rst[g])       cnt <= 8'd0;
         else if (cnt == cmax) cnt <= 8'd0;
         else                  cnt <= cnt + 8'd1;
      end

      uart_tx_ctrl #(
         .DATA_BITS (8),
         .STOP_BITS ((g == 0) ? 1 : 2),
         .PARITY_EN ((g == 0) ? 0 : 1),
         .PARITY_ODD((g == 2) ? 1 : 0)
      ) u_dut (
         .i_clk      (clk),
         .i_rst_n    (rst_n),
         .i_freq     (freq),
         .i_data     (data),
         .i_valid    (valid[g]),
         .o_ready    (ready[g]),
         .o_tx       (tx[g]),
         .o_busy     (busy[g]),
         .o_done     (done[g]),
         .o_div_rst  (div_rst[g]),
         .o_freq     (dfreq[g]),
         .i_baud_tick(tick[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
   endtask

   // Sends one frame on instance g and checks every cycle of every bit.
   // expv holds the expected line level per bit, bit 0 = start bit.
   // Called at a negedge; returns at the negedge of the o_done cycle.
   task automatic run_frame(input int g, input logic [7:0] d, input uart_freq f,
                            input int nbits, input logic [11:0] expv, input string tag,
                            input bit hold, input int exp_wait, input int sw_at);
      int m, t, bad, dn, nb, nr, cyc;
      m = cnt_of(f);
      data = d;
      freq = f;
      valid[g] = 1'b1;
      t = 0;
      while (!ready[g] && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_ready"}, 32'(ready[g]), 32'd1);
      if (exp_wait >= 0) check({tag, "_gap"}, t, exp_wait);
      @(posedge clk);
      #1;
      if (!hold) valid[g] = 1'b0;
      dn = 0; nb = 0; nr = 0; cyc = 0;
      for (int k = 0; k < nbits; k++) begin
         bad = 0;
         for (int c = 0; c <= m; c++) begin
            @(negedge clk);
            if (cyc == sw_at) freq = uart_115200;
            cyc++;
            if (tx[g] !== expv[k]) bad++;
            if (done[g]) dn++;
            if (!busy[g]) nb++;
            if (ready[g]) nr++;
         end
         check($sformatf("%s_bit%0d", tag, k), bad, 0);
      end
      check({tag, "_early_done"}, dn, 0);
      check({tag, "_busy_gap"}, nb, 0);
      check({tag, "_ready_in_frame"}, nr, 0);
      @(negedge clk);
      check({tag, "_done"}, 32'(done[g]), 32'd1);
      check({tag, "_busy_end"}, 32'(busy[g]), 32'd0);
      check({tag, "_ready_end"}, 32'(ready[g]), 32'd1);
      check({tag, "_tx_idle"}, 32'(tx[g]), 32'd1);
      check({tag, "_ofreq"}, 32'(dfreq[g]), 32'(f));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_r, bad_t, bad_d, cnt_d;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx",      32'(tx),      32'h7);
      check("rst_busy",    32'(busy),    32'h0);
      check("rst_done",    32'(done),    32'h0);
      check("rst_div_rst", 32'(div_rst), 32'h7);
      check("rst_ofreq",   32'(dfreq[0]), 32'(uart_9600));
      check("rst_ready",   32'(ready),   32'h7);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 8N1, A5: line 0,1,0,1,0,0,1,0,1,1
      run_frame(0, 8'hA5, uart_115200, 10, 12'h34A, "basic", 1'b0, -1, -1);
      @(negedge clk);
      // 8E2, 07: three ones -> even parity bit 1
      run_frame(1, 8'h07, uart_115200, 12, 12'hE0E, "even2", 1'b0, -1, -1);
      @(negedge clk);
      // 8O2, 07: odd parity bit 0
      run_frame(2, 8'h07, uart_57600, 12, 12'hC0E, "odd2", 1'b0, -1, -1);
      @(negedge clk);

      // Back-to-back with valid held: 55 then FF, zero wait at the boundary.
      run_frame(0, 8'h55, uart_115200, 10, 12'h2AA, "b2b_a", 1'b1, -1, -1);
      run_frame(0, 8'hFF, uart_115200, 10, 12'h3FE, "b2b_b", 1'b0, 0, -1);
      @(negedge clk);

      // Frequency latched at 9600; input switches to 115200 mid-frame.
      run_frame(0, 8'h3C, uart_9600, 10, 12'h278, "latch", 1'b0, -1, 300);
      @(negedge clk);
      run_frame(0, 8'hC3, uart_115200, 10, 12'h386, "relatch", 1'b0, -1, -1);
      @(negedge clk);

      // Unsupported frequency encoding never starts a frame.
      freq = uart_freq'(3'd6);
      valid = 3'b111;
      bad_r = 0; bad_t = 0; bad_d = 0;
      repeat (1000) begin
         @(negedge clk);
         if (ready != 3'b000) bad_r++;
         if (tx != 3'b111) bad_t++;
         if (div_rst != 3'b111) bad_d++;
      end
      check("badfreq_ready",   bad_r, 0);
      check("badfreq_tx",      bad_t, 0);
      check("badfreq_div_rst", bad_d, 0);
      valid = 3'b000;
      freq = uart_115200;
      @(negedge clk);

      // Reset in the data bit 3 window (frame bit 4) of a 96 frame.
      data = 8'h96;
      valid[0] = 1'b1;
      check("mid_ready", 32'(ready[0]), 32'd1);
      @(posedge clk);
      #1 valid[0] = 1'b0;
      repeat (4 * 16 + 8) @(negedge clk);
      check("mid_tx_bit3", 32'(tx[0]), 32'd0);
      check("mid_busy_pre", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_tx",      32'(tx[0]),      32'd1);
      check("mid_busy",    32'(busy[0]),    32'd0);
      check("mid_div_rst", 32'(div_rst[0]), 32'd1);
      check("mid_ofreq",   32'(dfreq[0]),   32'(uart_9600));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt_d = 0; bad_t = 0;
      repeat (200) begin
         @(negedge clk);
         if (done[0]) cnt_d++;
         if (tx[0] !== 1'b1) bad_t++;
      end
      check("mid_no_done", cnt_d, 0);
      check("mid_tx_idle", bad_t, 0);
      run_frame(0, 8'h96, uart_115200, 10, 12'h32C, "post_rst", 1'b0, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
